// File: rtl/lorenz_pkg.sv
// Shared types and fixed-point helpers for the TDM Lorenz integrator.
// Saturating arithmetic is selected by callers (LORENZ_SAT_EN).
package lorenz_pkg;

  localparam int MAXW = 64;
  localparam int WW   = 2 * MAXW + 2;

  typedef logic signed [MAXW-1:0] fx_t;
  typedef logic signed [WW-1:0]   wide_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } fsm_t;

  localparam wide_t WONE = 1;

  function automatic int ch_w(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Reduce an exact wide value to a size-bit signed value.
  function automatic fx_t fit(wide_t v, int size,
                              logic sat);
    wide_t hi, lo, w;
    int    sh;
    hi = (WONE <<< (size - 1)) - WONE;
    lo = -hi - WONE;
    sh = WW - size;
    w  = (v <<< sh) >>> sh;
    if (sat && v > hi) w = hi;
    else if (sat && v < lo) w = lo;
    return fx_t'(w);
  endfunction

  function automatic fx_t fx_mul(fx_t a, fx_t b,
                                 int pnt, int size,
                                 logic sat);
    wide_t p;
    p = (wide_t'(a) * wide_t'(b)) >>> pnt;
    return fit(p, size, sat);
  endfunction

  function automatic fx_t sat_add(fx_t a, fx_t b,
                                  logic sub, int size,
                                  logic sat);
    wide_t s;
    if (sub) s = wide_t'(a) - wide_t'(b);
    else     s = wide_t'(a) + wide_t'(b);
    return fit(s, size, sat);
  endfunction

endpackage

// File: rtl/lorenz_tdm_integrator_if.sv
// Load and result stream bundle for lorenz_tdm_integrator.
// master = host/readout side, slave = integrator.
interface lorenz_tdm_integrator_if
  import lorenz_pkg::*;
#(
  parameter int SIZE     = 64,
  parameter int CHANNELS = 4,
  parameter int STEP_W   = 32
);
  localparam int CW = ch_w(CHANNELS);

  logic                   ld_valid;
  logic                   ld_ready;
  logic [CW-1:0]          ld_ch;
  logic signed [SIZE-1:0] ld_x;
  logic signed [SIZE-1:0] ld_y;
  logic signed [SIZE-1:0] ld_z;

  logic                   out_valid;
  logic                   out_ready;
  logic [CW-1:0]          out_ch;
  logic signed [SIZE-1:0] out_x;
  logic signed [SIZE-1:0] out_y;
  logic signed [SIZE-1:0] out_z;
  logic [STEP_W-1:0]      out_step;

  modport master (
    output ld_valid, ld_ch,
    output ld_x, ld_y, ld_z,
    output out_ready,
    input  ld_ready,
    input  out_valid, out_ch,
    input  out_x, out_y, out_z,
    input  out_step
  );

  modport slave (
    input  ld_valid, ld_ch,
    input  ld_x, ld_y, ld_z,
    input  out_ready,
    output ld_ready,
    output out_valid, out_ch,
    output out_x, out_y, out_z,
    output out_step
  );

endinterface

// File: rtl/lorenz_euler_step.sv
// Combinational forward-Euler Lorenz step for one channel.
// LORENZ_SAT_EN: saturate every op and report overflow.
module lorenz_euler_step
  import lorenz_pkg::*;
#(
  parameter int SIZE     = 64,
  parameter int PNT      = 48,
  parameter int FAC_SIZE = 3
)(
  input  logic signed [SIZE-1:0] x_i,
  input  logic signed [SIZE-1:0] y_i,
  input  logic signed [SIZE-1:0] z_i,
  input  logic signed [SIZE-1:0] sigma_i,
  input  logic signed [SIZE-1:0] rho_i,
  input  logic signed [SIZE-1:0] beta_i,
  input  logic [FAC_SIZE:0]      factor_i,
  output logic signed [SIZE-1:0] x_o,
  output logic signed [SIZE-1:0] y_o,
  output logic signed [SIZE-1:0] z_o
`ifdef LORENZ_SAT_EN
  ,
  output logic                   ovf_o
`endif
);

`ifdef LORENZ_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  fx_t x, y, z, sg, rh, bt;
  fx_t ymx, rmz, xr, xy, bz;
  fx_t dx, dy, dz, sdx, sdy, sdz;
  fx_t nx, ny, nz;

  always_comb begin
    x   = fx_t'(x_i);
    y   = fx_t'(y_i);
    z   = fx_t'(z_i);
    sg  = fx_t'(sigma_i);
    rh  = fx_t'(rho_i);
    bt  = fx_t'(beta_i);
    ymx = sat_add(y, x, 1'b1, SIZE, SAT);
    dx  = fx_mul(sg, ymx, PNT, SIZE, SAT);
    rmz = sat_add(rh, z, 1'b1, SIZE, SAT);
    xr  = fx_mul(x, rmz, PNT, SIZE, SAT);
    dy  = sat_add(xr, y, 1'b1, SIZE, SAT);
    xy  = fx_mul(x, y, PNT, SIZE, SAT);
    bz  = fx_mul(bt, z, PNT, SIZE, SAT);
    dz  = sat_add(xy, bz, 1'b1, SIZE, SAT);
    sdx = dx >>> factor_i;
    sdy = dy >>> factor_i;
    sdz = dz >>> factor_i;
    nx  = sat_add(x, sdx, 1'b0, SIZE, SAT);
    ny  = sat_add(y, sdy, 1'b0, SIZE, SAT);
    nz  = sat_add(z, sdz, 1'b0, SIZE, SAT);
  end

  assign x_o = nx[SIZE-1:0];
  assign y_o = ny[SIZE-1:0];
  assign z_o = nz[SIZE-1:0];

`ifdef LORENZ_SAT_EN
  // An op overflowed when its clamped and wrapped results differ.
  function automatic logic mo(fx_t a, fx_t b);
    return fx_mul(a, b, PNT, SIZE, 1'b1) !=
           fx_mul(a, b, PNT, SIZE, 1'b0);
  endfunction

  function automatic logic ao(fx_t a, fx_t b,
                              logic sub);
    return sat_add(a, b, sub, SIZE, 1'b1) !=
           sat_add(a, b, sub, SIZE, 1'b0);
  endfunction

  assign ovf_o = mo(sg, ymx) | mo(x, rmz) |
                 mo(x, y) | mo(bt, z) |
                 ao(y, x, 1'b1) | ao(rh, z, 1'b1) |
                 ao(xr, y, 1'b1) | ao(xy, bz, 1'b1) |
                 ao(x, sdx, 1'b0) | ao(y, sdy, 1'b0) |
                 ao(z, sdz, 1'b0);
`endif

endmodule

// File: rtl/lorenz_tdm_integrator.sv
// Round-robin TDM Lorenz integrator: FSM, channel regs, streams.
// LORENZ_SAT_EN adds saturation and the sticky overflow output.
module lorenz_tdm_integrator
  import lorenz_pkg::*;
#(
  parameter int SIZE     = 64,
  parameter int PNT      = 48,
  parameter int FAC_SIZE = 3,
  parameter int CHANNELS = 4,
  parameter int STEP_W   = 32
)(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [STEP_W-1:0]      steps,
  input  logic signed [SIZE-1:0] sigma,
  input  logic signed [SIZE-1:0] rho,
  input  logic signed [SIZE-1:0] beta,
  input  logic [FAC_SIZE:0]      factor,
  lorenz_tdm_integrator_if.slave bus,
  output logic                   busy,
  output logic                   done
`ifdef LORENZ_SAT_EN
  ,
  output logic                   overflow
`endif
);

  localparam int CW = ch_w(CHANNELS);

  typedef logic signed [SIZE-1:0] val_t;

  fsm_t              state_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] step_q;
  logic [CW-1:0]     ptr_q;

  val_t xs_q [CHANNELS];
  val_t ys_q [CHANNELS];
  val_t zs_q [CHANNELS];

  val_t              ox_q, oy_q, oz_q;
  logic [CW-1:0]     och_q;
  logic [STEP_W-1:0] ostep_q;
  logic              ovalid_q;
  logic              done_q;

  val_t x_d, y_d, z_d;
  val_t cx, cy, cz;
  logic ended, slot, fin, last, ld_in;

  assign cx = xs_q[ptr_q];
  assign cy = ys_q[ptr_q];
  assign cz = zs_q[ptr_q];

  assign ended = (steps_q != '0) &&
                 (step_q == steps_q);
  assign slot  = (state_q == RUN) && !ended &&
                 (!ovalid_q || bus.out_ready);
  assign fin   = ovalid_q && bus.out_ready && ended;
  assign last  = 32'(ptr_q) == 32'(CHANNELS - 1);
  assign ld_in = 32'(bus.ld_ch) < 32'(CHANNELS);

`ifdef LORENZ_SAT_EN
  logic step_ovf;
  logic ovf_q;
  assign overflow = ovf_q;
`endif

  lorenz_euler_step #(
    .SIZE     (SIZE),
    .PNT      (PNT),
    .FAC_SIZE (FAC_SIZE)
  ) u_step (
    .x_i      (cx),
    .y_i      (cy),
    .z_i      (cz),
    .sigma_i  (sigma),
    .rho_i    (rho),
    .beta_i   (beta),
    .factor_i (factor),
    .x_o      (x_d),
    .y_o      (y_d),
    .z_o      (z_d)
`ifdef LORENZ_SAT_EN
    ,
    .ovf_o    (step_ovf)
`endif
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      steps_q  <= '0;
      step_q   <= '0;
      ptr_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        xs_q[i] <= '0;
        ys_q[i] <= '0;
        zs_q[i] <= '0;
      end
      ox_q     <= '0;
      oy_q     <= '0;
      oz_q     <= '0;
      och_q    <= '0;
      ostep_q  <= '0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef LORENZ_SAT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.ld_valid && ld_in) begin
            xs_q[bus.ld_ch] <= bus.ld_x;
            ys_q[bus.ld_ch] <= bus.ld_y;
            zs_q[bus.ld_ch] <= bus.ld_z;
          end
          if (start && !abort) begin
            state_q <= RUN;
            steps_q <= steps;
            step_q  <= '0;
            ptr_q   <= '0;
`ifdef LORENZ_SAT_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (abort) begin
            state_q  <= IDLE;
            ovalid_q <= 1'b0;
          end else begin
            if (slot) begin
              xs_q[ptr_q] <= x_d;
              ys_q[ptr_q] <= y_d;
              zs_q[ptr_q] <= z_d;
              ox_q        <= x_d;
              oy_q        <= y_d;
              oz_q        <= z_d;
              och_q       <= ptr_q;
              ostep_q     <= step_q + 1'b1;
              ovalid_q    <= 1'b1;
              ptr_q       <= last ? '0 : ptr_q + 1'b1;
              if (last) step_q <= step_q + 1'b1;
`ifdef LORENZ_SAT_EN
              ovf_q       <= ovf_q | step_ovf;
`endif
            end else if (bus.out_ready) begin
              ovalid_q <= 1'b0;
            end
            if (fin) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready  = (state_q == IDLE);
  assign bus.out_valid = ovalid_q;
  assign bus.out_ch    = och_q;
  assign bus.out_x     = ox_q;
  assign bus.out_y     = oy_q;
  assign bus.out_z     = oz_q;
  assign bus.out_step  = ostep_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_lorenz_tdm_integrator.sv
// Scoreboard bench for lorenz_tdm_integrator, 4 channels.
// Build with LORENZ_SAT_EN to exercise the saturating variant.
module tb_lorenz_tdm_integrator;

  typedef logic signed [63:0]  v_t;
  typedef logic signed [129:0] w_t;
  typedef struct {
    logic [1:0]  ch;
    logic [31:0] step;
    v_t          x, y, z;
  } beat_t;

`ifdef LORENZ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam w_t MAXV = 130'sh7FFF_FFFF_FFFF_FFFF;
  localparam w_t MINV = -MAXV - 130'sd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] steps;
  v_t          sg, rh, bt;
  logic [3:0]  fac;
  logic        busy, done;
`ifdef LORENZ_SAT_EN
  logic        overflow;
`endif

  int    checks = 0;
  int    errors = 0;
  int    nbeats = 0;
  int    ndone  = 0;
  beat_t sbq[$];
  v_t    mx[4], my[4], mz[4];

  always #5 clk = ~clk;

  lorenz_tdm_integrator_if #(
    .SIZE(64), .CHANNELS(4), .STEP_W(32)
  ) bus ();

  lorenz_tdm_integrator #(
    .SIZE(64), .PNT(48), .FAC_SIZE(3),
    .CHANNELS(4), .STEP_W(32)
  ) dut (
    .clock  (clk),
    .reset  (rst_n),
    .start  (start),
    .abort  (abort),
    .steps  (steps),
    .sigma  (sg),
    .rho    (rh),
    .beta   (bt),
    .factor (fac),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
`ifdef LORENZ_SAT_EN
    ,
    .overflow (overflow)
`endif
  );

  function automatic v_t fx(int i);
    v_t v;
    v = i;
    return v <<< 48;
  endfunction

  function automatic v_t fitm(w_t v);
    if (SAT && v > MAXV) return v_t'(MAXV);
    if (SAT && v < MINV) return v_t'(MINV);
    return v[63:0];
  endfunction

  function automatic v_t mmul(v_t a, v_t b);
    w_t p;
    p = a;
    p = p * w_t'(b);
    p = p >>> 48;
    return fitm(p);
  endfunction

  function automatic v_t madd(v_t a, v_t b);
    w_t p;
    p = a;
    p = p + w_t'(b);
    return fitm(p);
  endfunction

  function automatic v_t msub(v_t a, v_t b);
    w_t p;
    p = a;
    p = p - w_t'(b);
    return fitm(p);
  endfunction

  task automatic plan(int rounds);
    beat_t b;
    v_t x, y, z, dx, dy, dz;
    for (int s = 1; s <= rounds; s++) begin
      for (int c = 0; c < 4; c++) begin
        x  = mx[c];
        y  = my[c];
        z  = mz[c];
        dx = mmul(sg, msub(y, x));
        dy = msub(mmul(x, msub(rh, z)), y);
        dz = msub(mmul(x, y), mmul(bt, z));
        mx[c] = madd(x, dx >>> fac);
        my[c] = madd(y, dy >>> fac);
        mz[c] = madd(z, dz >>> fac);
        b.ch   = 2'(c);
        b.step = 32'(s);
        b.x    = mx[c];
        b.y    = my[c];
        b.z    = mz[c];
        sbq.push_back(b);
      end
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && bus.out_valid === 1'b1 &&
        bus.out_ready) begin
      nbeats++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL beat_extra got ch %0d step %0d want none",
                 bus.out_ch, bus.out_step);
      end else begin
        e = sbq.pop_front();
        if (bus.out_ch !== e.ch || bus.out_step !== e.step ||
            bus.out_x !== e.x || bus.out_y !== e.y ||
            bus.out_z !== e.z) begin
          errors++;
          $display("FAIL beat got ch%0d s%0d %h %h %h want ch%0d s%0d %h %h %h",
                   bus.out_ch, bus.out_step, bus.out_x, bus.out_y,
                   bus.out_z, e.ch, e.step, e.x, e.y, e.z);
        end
      end
    end
    if (rst_n && done === 1'b1) ndone++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int c, v_t x, v_t y, v_t z);
    bus.ld_valid = 1'b1;
    bus.ld_ch    = 2'(c);
    bus.ld_x     = x;
    bus.ld_y     = y;
    bus.ld_z     = z;
    tick();
    bus.ld_valid = 1'b0;
    mx[c] = x;
    my[c] = y;
    mz[c] = z;
  endtask

  task automatic load_all(int k);
    for (int c = 0; c < 4; c++)
      load(c, fx(c + k), fx(k - c), fx(2 * c + 1));
  endtask

  task automatic go(int st);
    nbeats = 0;
    ndone  = 0;
    steps  = 32'(st);
    plan(st == 0 ? 3 : st);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got b%b d%b v%b want 000",
               busy, done, bus.out_valid);
    end
    checks++;
    if (bus.out_x !== 64'd0 || bus.out_step !== 32'd0 ||
        bus.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_out got x %h s %0d r %b want 0 0 1",
               bus.out_x, bus.out_step, bus.ld_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    for (int c = 1; c < 4; c++)
      load(c, fx(c + 1), fx(-c), fx(2 * c));
    load(0, fx(1), fx(1), fx(1));
    go(1);
    checks++;
    if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_e0 got b%b v%b want b1 v0",
               busy, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 ||
        bus.out_step !== 32'd1) begin
      errors++;
      $display("FAIL single_e1 got v%b ch%0d s%0d want v1 ch0 s1",
               bus.out_valid, bus.out_ch, bus.out_step);
    end
    checks++;
    if (bus.out_x !== 64'h0001_0000_0000_0000 ||
        bus.out_y !== 64'h0004_4000_0000_0000 ||
        bus.out_z !== 64'h0000_E000_0000_0000) begin
      errors++;
      $display("FAIL single_xyz got %h %h %h want 1.0 4.25 0.875",
               bus.out_x, bus.out_y, bus.out_z);
    end
    repeat (4) tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL single_done got %b want 1", done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ndone != 1 ||
        nbeats != 4 || sbq.size() != 0) begin
      errors++;
      $display("FAIL single_end got d%b b%b nd%0d nb%0d q%0d want 0 0 1 4 0",
               done, busy, ndone, nbeats, sbq.size());
    end
  endtask

  task automatic test_multi();
    bit seen;
    load_all(3);
    go(3);
    wait_done(100, seen);
    tick();
    checks++;
    if (!seen || nbeats != 12 || ndone != 1 ||
        sbq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL multi got seen%b nb%0d nd%0d q%0d b%b want 1 12 1 0 0",
               seen, nbeats, ndone, sbq.size(), busy);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    load_all(-2);
    go(2);
    repeat (3) tick();
    bus.out_ready = 1'b0;
    bus.ld_valid  = 1'b1;
    bus.ld_ch     = 2'd1;
    bus.ld_x      = fx(99);
    bus.ld_y      = fx(99);
    bus.ld_z      = fx(99);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== sbq[0].ch ||
          bus.out_step !== sbq[0].step ||
          bus.out_x !== sbq[0].x || bus.ld_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold got v%b ch%0d s%0d x %h r%b want 1 %0d %0d %h 0",
                 bus.out_valid, bus.out_ch, bus.out_step, bus.out_x,
                 bus.ld_ready, sbq[0].ch, sbq[0].step, sbq[0].x);
      end
    end
    bus.out_ready = 1'b1;
    bus.ld_valid  = 1'b0;
    wait_done(100, seen);
    tick();
    checks++;
    if (!seen || nbeats != 8 || sbq.size() != 0) begin
      errors++;
      $display("FAIL bp_end got seen%b nb%0d q%0d want 1 8 0",
               seen, nbeats, sbq.size());
    end
  endtask

  task automatic test_abort();
    go(0);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort got b%b v%b want 0 0",
               busy, bus.out_valid);
    end
    repeat (3) tick();
    checks++;
    if (ndone != 0 || bus.ld_ready !== 1'b1 ||
        nbeats < 5) begin
      errors++;
      $display("FAIL abort_after got nd%0d r%b nb%0d want 0 1 >=5",
               ndone, bus.ld_ready, nbeats);
    end
    sbq.delete();
    load_all(1);
  endtask

  task automatic test_reset_midrun();
    go(2);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 ||
        bus.ld_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl got v%b b%b r%b d%b want 0 0 1 0",
               bus.out_valid, busy, bus.ld_ready, done);
    end
    checks++;
    if (bus.out_x !== 64'd0 || bus.out_y !== 64'd0 ||
        bus.out_z !== 64'd0 || bus.out_ch !== 2'd0 ||
        bus.out_step !== 32'd0) begin
      errors++;
      $display("FAIL rst_out got %h %h %h ch%0d s%0d want zeros",
               bus.out_x, bus.out_y, bus.out_z,
               bus.out_ch, bus.out_step);
    end
    sbq.delete();
    for (int c = 0; c < 4; c++) begin
      mx[c] = '0;
      my[c] = '0;
      mz[c] = '0;
    end
    go(1);
    repeat (8) tick();
    checks++;
    if (nbeats != 4 || sbq.size() != 0) begin
      errors++;
      $display("FAIL rst_zero got nb%0d q%0d want 4 0",
               nbeats, sbq.size());
    end
  endtask

  task automatic test_overflow();
    bit seen;
    load_all(2);
    load(0, fx(-30000), fx(30000), fx(0));
    sg  = fx(10);
    fac = 4'd0;
    go(1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0) begin
      errors++;
      $display("FAIL ovf_beat got v%b ch%0d want 1 0",
               bus.out_valid, bus.out_ch);
    end
`ifdef LORENZ_SAT_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got %b want 1", overflow);
    end
`else
    checks++;
    if (bus.out_x !== 64'hB290_0000_0000_0000) begin
      errors++;
      $display("FAIL ovf_wrap got %h want b290000000000000",
               bus.out_x);
    end
`endif
    wait_done(50, seen);
    tick();
    checks++;
    if (!seen || nbeats != 4 || sbq.size() != 0) begin
      errors++;
      $display("FAIL ovf_end got seen%b nb%0d q%0d want 1 4 0",
               seen, nbeats, sbq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    steps         = '0;
    sg            = fx(10);
    rh            = fx(28);
    bt            = fx(2);
    fac           = 4'd3;
    bus.ld_valid  = 1'b0;
    bus.ld_ch     = '0;
    bus.ld_x      = '0;
    bus.ld_y      = '0;
    bus.ld_z      = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mx[c] = '0;
      my[c] = '0;
      mz[c] = '0;
    end
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_abort();
    test_reset_midrun();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
